keypad_scan: RTL and testbench

- Scans a 4x4 hex matrix keypad on a Pmod connector and is the input-side counterpart of the multiplexed 7-segment display driver.
- Drives one column low at a time, samples the rows, debounces, and decodes each key press to a 4-bit hex code.
- Shifts each accepted digit into a 16-bit word that can feed the display data path or a register load directly.
- Runs from the 10 MHz system clock.

---
 rtl/keypad_scan_if.sv | 12 +
 rtl/keypad_scan.sv | 126 ++++++++++++
 tb/tb_keypad_scan.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad row/column lines plus the decoded-key and digit-word outputs.
interface keypad_scan_if;
  logic [3:0]  row_i;
  logic        clr_i;
  logic [3:0]  col_o;
  logic        key_valid_o;
  logic [3:0]  key_code_o;
  logic        key_held_o;
  logic [15:0] data_o;
  modport master (output row_i, clr_i, input col_o, key_valid_o, key_code_o, key_held_o, data_o);
  modport slave (input row_i, clr_i, output col_o, key_valid_o, key_code_o, key_held_o, data_o);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 hex keypad scanner with debounce, one-shot key pulse and a 4-digit shift word.
module keypad_scan #(
  parameter int SCAN_TICKS     = 10_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  keypad_scan_if.slave kp
);
  localparam int TW = $clog2(SCAN_TICKS);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_SCANS);
  // nibble {row,col} holds the hex legend of that key
  localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;
  state_t        r_state, w_state_nxt;
  logic [3:0]    r_sync1, r_sync2;
  logic [TW-1:0] r_tick;
  logic [1:0]    r_col_idx, w_col_nxt;
  logic [DW-1:0] r_deb, w_deb_nxt;
  logic [1:0]    r_row, w_row_nxt, w_row_enc, w_acc_row;
  logic [3:0]    r_pat, w_pat_nxt;
  logic          r_valid, r_held;
  logic [3:0]    r_code, w_code;
  logic [15:0]   r_data;
  logic          w_sample, w_one_low, w_accept, w_release;
  logic [3:0]    w_low;
  assign w_sample  = r_tick == TW'(SCAN_TICKS - 1);
  assign w_low     = ~r_sync2;
  assign w_one_low = (w_low != 4'h0) && ((w_low & (w_low - 4'h1)) == 4'h0);
  assign w_row_enc = w_low[0] ? 2'd0 : w_low[1] ? 2'd1 : w_low[2] ? 2'd2 : 2'd3;
  assign w_code    = KEYMAP[{w_acc_row, r_col_idx, 2'b00} +: 4];
  assign kp.col_o       = ~(4'b0001 << r_col_idx);
  assign kp.key_valid_o = r_valid;
  assign kp.key_code_o  = r_code;
  assign kp.key_held_o  = r_held;
  assign kp.data_o      = r_data;
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col_idx;
    w_deb_nxt   = r_deb;
    w_row_nxt   = r_row;
    w_pat_nxt   = r_pat;
    w_acc_row   = r_row;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    if (w_sample) begin
      case (r_state)
        SCAN: begin
          if (w_one_low) begin
            w_pat_nxt = r_sync2;
            w_row_nxt = w_row_enc;
            w_acc_row = w_row_enc;
            w_deb_nxt = DW'(1);
            if (DEB_MAX == DW'(1)) begin
              w_state_nxt = PRESSED;
              w_accept    = 1'b1;
              w_deb_nxt   = '0;
            end else begin
              w_state_nxt = DEBOUNCE;
            end
          end else begin
            w_col_nxt = r_col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (r_sync2 == r_pat) begin
            w_deb_nxt = r_deb + 1'b1;
            if (w_deb_nxt == DEB_MAX) begin
              w_state_nxt = PRESSED;
              w_accept    = 1'b1;
              w_deb_nxt   = '0;
            end
          end else begin
            w_state_nxt = SCAN;
            w_col_nxt   = r_col_idx + 2'd1;
          end
        end
        PRESSED: begin
          if (r_sync2 == 4'hF) begin
            w_deb_nxt = r_deb + 1'b1;
            if (w_deb_nxt == DEB_MAX) begin
              w_state_nxt = SCAN;
              w_col_nxt   = r_col_idx + 2'd1;
              w_release   = 1'b1;
              w_deb_nxt   = '0;
            end
          end else begin
            w_deb_nxt = '0;
          end
        end
        default: w_state_nxt = SCAN;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= SCAN;
      r_sync1   <= 4'hF;
      r_sync2   <= 4'hF;
      r_tick    <= '0;
      r_col_idx <= 2'd0;
      r_deb     <= '0;
      r_row     <= 2'd0;
      r_pat     <= 4'hF;
      r_valid   <= 1'b0;
      r_held    <= 1'b0;
      r_code    <= 4'h0;
      r_data    <= 16'h0000;
    end else begin
      r_state   <= w_state_nxt;
      r_sync1   <= kp.row_i;
      r_sync2   <= r_sync1;
      r_tick    <= w_sample ? '0 : r_tick + 1'b1;
      r_col_idx <= w_col_nxt;
      r_deb     <= w_deb_nxt;
      r_row     <= w_row_nxt;
      r_pat     <= w_pat_nxt;
      r_valid   <= w_accept;
      r_held    <= w_accept ? 1'b1 : w_release ? 1'b0 : r_held;
      r_code    <= w_accept ? w_code : r_code;
      r_data    <= kp.clr_i ? (w_accept ? {12'h000, w_code} : 16'h0000)
                            : (w_accept ? {r_data[11:0], w_code} : r_data);
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad model driving rows from the column drive, scoreboard of expected key pulses.
module tb_keypad_scan;
  typedef struct {logic [1:0] r; logic [1:0] c; logic [3:0] code; logic [15:0] data;} vec_t;
  typedef struct {logic [3:0] code; logic [15:0] data;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_on = 1'b0, multi = 1'b0, ovr_en = 1'b0;
  logic [1:0] key_r = 2'd0, key_c = 2'd0;
  logic [3:0] ovr_row = 4'hF;
  int n_cmp = 0, n_bad = 0;
  exp_t sb[$];
  exp_t e;
  vec_t tbl[6];
  keypad_scan_if kif();
  keypad_scan #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(2)) dut (.clk_i(clk), .rst_i(rst_n), .kp(kif));
  always #5 clk = ~clk;
  assign kif.row_i = ovr_en ? ovr_row
                   : (multi && kif.col_o == 4'b1110) ? 4'b1010
                   : (key_on && !kif.col_o[key_c]) ? ~(4'b0001 << key_r) : 4'hF;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask
  always @(negedge clk) begin
    if (kif.key_valid_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got code %h data %h expected no pulse", kif.key_code_o, kif.data_o);
      end else begin
        e = sb.pop_front();
        chk("pulse_code", {28'd0, kif.key_code_o}, {28'd0, e.code});
        chk("pulse_data", {16'd0, kif.data_o}, {16'd0, e.data});
        chk("pulse_held", {31'd0, kif.key_held_o}, 32'd1);
      end
    end
  end
  task automatic wait_release(input logic [1:0] c);
    logic done = 1'b0;
    logic [1:0] nc = c + 2'd1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = !kif.key_held_o;
    end
    chk("release_seen", {31'd0, done}, 32'd1);
    chk("col_resume", {28'd0, kif.col_o}, {28'd0, ~(4'b0001 << nc)});
  endtask
  task automatic press(input logic [1:0] r, input logic [1:0] c, input logic [3:0] code,
                       input logic [15:0] data, input logic clr);
    logic got = 1'b0;
    sb.push_back('{code, data});
    key_r = r;
    key_c = c;
    key_on = 1'b1;
    kif.clr_i = clr;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      got = kif.key_valid_o;
    end
    kif.clr_i = 1'b0;
    chk("press_seen", {31'd0, got}, 32'd1);
    repeat (20) @(negedge clk);
    chk("code_hold", {28'd0, kif.key_code_o}, {28'd0, code});
    chk("held_hold", {31'd0, kif.key_held_o}, 32'd1);
    key_on = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_after_release", {31'd0, kif.key_held_o}, 32'd1);
    wait_release(c);
  endtask
  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [1:0] idx;
    logic [3:0] prev;
    logic got;
    int changes;
    tbl[0] = '{2'd1, 2'd1, 4'h5, 16'h0005};
    tbl[1] = '{2'd0, 2'd0, 4'h1, 16'h0051};
    tbl[2] = '{2'd0, 2'd1, 4'h2, 16'h0512};
    tbl[3] = '{2'd0, 2'd2, 4'h3, 16'h5123};
    tbl[4] = '{2'd0, 2'd3, 4'hA, 16'h123A};
    tbl[5] = '{2'd3, 2'd0, 4'h0, 16'h23A0};
    kif.clr_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col", {28'd0, kif.col_o}, 32'he);
    chk("rst_valid", {31'd0, kif.key_valid_o}, 32'd0);
    chk("rst_code", {28'd0, kif.key_code_o}, 32'd0);
    chk("rst_held", {31'd0, kif.key_held_o}, 32'd0);
    chk("rst_data", {16'd0, kif.data_o}, 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      repeat (4) @(negedge clk);
      idx = k[1:0];
      chk("idle_col", {28'd0, kif.col_o}, {28'd0, ~(4'b0001 << idx)});
    end
    chk("idle_data", {16'd0, kif.data_o}, 32'd0);
    for (int i = 0; i < 6; i++) press(tbl[i].r, tbl[i].c, tbl[i].code, tbl[i].data, 1'b0);
    // single-sample bounce on row0 of column 0
    got = 1'b0;
    prev = kif.col_o;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = kif.col_o == 4'b1110 && prev != 4'b1110;
      prev = kif.col_o;
    end
    chk("bounce_sync", {31'd0, got}, 32'd1);
    ovr_row = 4'b1110;
    ovr_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("bounce_frozen", {28'd0, kif.col_o}, 32'he);
    ovr_row = 4'hF;
    repeat (4) @(negedge clk);
    ovr_en = 1'b0;
    chk("bounce_advance", {28'd0, kif.col_o}, 32'hd);
    chk("bounce_data", {16'd0, kif.data_o}, 32'h23A0);
    chk("bounce_held", {31'd0, kif.key_held_o}, 32'd0);
    multi = 1'b1;
    changes = 0;
    prev = kif.col_o;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kif.col_o != prev) changes++;
      prev = kif.col_o;
    end
    multi = 1'b0;
    chk("multi_scan", {31'd0, changes >= 8}, 32'd1);
    chk("multi_data", {16'd0, kif.data_o}, 32'h23A0);
    kif.clr_i = 1'b1;
    @(negedge clk);
    kif.clr_i = 1'b0;
    chk("clr_data", {16'd0, kif.data_o}, 32'd0);
    chk("clr_code", {28'd0, kif.key_code_o}, 32'd0);
    kif.clr_i = 1'b0;
    press(2'd3, 2'd3, 4'hD, 16'h000D, 1'b1);
    // reset while a key is held, then expect one fresh pulse
    sb.push_back('{4'h5, 16'h00D5});
    key_r = 2'd1;
    key_c = 2'd1;
    key_on = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      got = kif.key_valid_o;
    end
    chk("pre_rst_pulse", {31'd0, got}, 32'd1);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_col", {28'd0, kif.col_o}, 32'he);
    chk("async_code", {28'd0, kif.key_code_o}, 32'd0);
    chk("async_held", {31'd0, kif.key_held_o}, 32'd0);
    chk("async_data", {16'd0, kif.data_o}, 32'd0);
    @(negedge clk);
    sb.push_back('{4'h5, 16'h0005});
    rst_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      got = kif.key_valid_o;
    end
    chk("post_rst_pulse", {31'd0, got}, 32'd1);
    repeat (20) @(negedge clk);
    key_on = 1'b0;
    wait_release(2'd1);
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
